// File: rtl/mid_test_slot_pkg.sv
// Shared types and constants for the midterm test-slot responder.
package mid_test_slot_pkg;

    // Run sequencing states of the slot controller.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_DRAIN  = 2'd2,
        S_REPORT = 2'd3
    } state_e;

    localparam logic RES_PASS = 1'b1;
    localparam logic RES_FAIL = 1'b0;

endpackage

// File: rtl/mid_test_slot_if.sv
// Sequencer/DUT-side bus of one test slot.
// The master side issues start and provides DUT and expected data.
// The slave side is the slot itself.
interface mid_test_slot_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int ERR_W  = 8
);
    logic              start;
    logic              stim_valid;
    logic [ADDR_W-1:0] stim_addr;
    logic [DATA_W-1:0] dut_data;
    logic              cmp_valid;
    logic [ADDR_W-1:0] cmp_addr;
    logic [DATA_W-1:0] exp_data;
    logic              busy;
    logic              done;
    logic              result;
    logic [ERR_W-1:0]  err_cnt;
    logic [ADDR_W-1:0] first_err;

    modport master (
        output start, dut_data, exp_data,
        input  stim_valid, stim_addr, cmp_valid, cmp_addr,
               busy, done, result, err_cnt, first_err
    );

    modport slave (
        input  start, dut_data, exp_data,
        output stim_valid, stim_addr, cmp_valid, cmp_addr,
               busy, done, result, err_cnt, first_err
    );
endinterface

// File: rtl/mid_delay_line.sv
// Fixed-latency shift register carrying {valid, addr} from stimulus to compare.
// pend_o flags a valid entry in any stage except the output stage, i.e. a compare
// that is still to come after the current cycle.
module mid_delay_line #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             clr_n_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             pend_o
);
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    // Next-stage values: shift by one position each cycle.
    always_comb begin
        stage_d[0] = din_i;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Stage registers with synchronous flush.
    always_ff @(posedge clk_i) begin
        if (!clr_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    // Any valid entry that has not yet reached the output stage.
    always_comb begin
        pend_o = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            pend_o = pend_o | stage_q[i][WIDTH-1];
        end
    end

    assign dout_o = stage_q[DEPTH-1];
endmodule

// File: rtl/mid_test_slot.sv
// Self-checking responder for one test slot: sweeps vector addresses, compares
// DUT responses against the expected table and reports pass/fail bookkeeping.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for start
// S_RUN    | presenting vector addresses 0..NUM_VEC-1, one per cycle
// S_DRAIN  | stimulus finished, waiting for in-flight compares to retire
// S_REPORT | one-cycle done pulse; result latched; start here re-arms
//
// REPORT accepts start directly so held-start runs repeat every
// NUM_VEC+DUT_LAT+1 cycles without an IDLE gap.
module mid_test_slot
    import mid_test_slot_pkg::*;
#(
    parameter int NUM_VEC = 16,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8,
    parameter int DUT_LAT = 2,
    parameter int ERR_W   = 8
) (
    input  logic              clk_i,
    input  logic              rstn1_i,
    mid_test_slot_if.slave    bus
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_VEC - 1);

    state_e            state_q, state_d;
    logic              launch;
    logic              stim_valid;
    logic              done;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [ADDR_W-1:0] ferr_q, ferr_d;
    logic              result_q, result_d;
    logic [ADDR_W:0]   dl_out;
    logic              dl_pend;
    logic              cmp_valid;
    logic [ADDR_W-1:0] cmp_addr;
    logic              mismatch;

    mid_delay_line #(
        .WIDTH(ADDR_W + 1),
        .DEPTH(DUT_LAT)
    ) u_delay (
        .clk_i  (clk_i),
        .clr_n_i(rstn1_i),
        .din_i  ({stim_valid, addr_q}),
        .dout_o (dl_out),
        .pend_o (dl_pend)
    );

    assign cmp_valid = dl_out[ADDR_W];
    assign cmp_addr  = dl_out[ADDR_W-1:0];
    // X/Z on the DUT side must count as a mismatch, hence the case inequality.
    assign mismatch  = cmp_valid && (DATA_W'(bus.dut_data) !== DATA_W'(bus.exp_data));

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (!rstn1_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and per-state strobes.
    always_comb begin
        state_d    = state_q;
        launch     = 1'b0;
        stim_valid = 1'b0;
        done       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    launch  = 1'b1;
                end
            end
            S_RUN: begin
                stim_valid = 1'b1;
                if (addr_q == LAST_ADDR) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!dl_pend) begin
                    state_d = S_REPORT;
                end
            end
            S_REPORT: begin
                done = 1'b1;
                if (bus.start) begin
                    state_d = S_RUN;
                    launch  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Address counter, saturating error count, first-failure capture and result.
    always_comb begin
        addr_d   = addr_q;
        err_d    = err_q;
        ferr_d   = ferr_q;
        result_d = result_q;
        if (launch) begin
            addr_d = '0;
            err_d  = '0;
            ferr_d = '0;
        end else begin
            if (state_q == S_RUN && addr_q != LAST_ADDR) begin
                addr_d = addr_q + 1'b1;
            end
            if (mismatch) begin
                if (err_q == '0) begin
                    ferr_d = cmp_addr;
                end
                if (err_q != '1) begin
                    err_d = err_q + 1'b1;
                end
            end
        end
        if (state_q == S_REPORT) begin
            result_d = (err_q == '0) ? RES_PASS : RES_FAIL;
        end else if (launch) begin
            result_d = RES_FAIL;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i) begin
        if (!rstn1_i) begin
            addr_q   <= '0;
            err_q    <= '0;
            ferr_q   <= '0;
            result_q <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            err_q    <= err_d;
            ferr_q   <= ferr_d;
            result_q <= result_d;
        end
    end

    assign bus.stim_valid = stim_valid;
    assign bus.stim_addr  = addr_q;
    assign bus.cmp_valid  = cmp_valid;
    assign bus.cmp_addr   = cmp_addr;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = done;
    assign bus.result     = result_q;
    assign bus.err_cnt    = err_q;
    assign bus.first_err  = ferr_q;
endmodule

// File: tb/tb_mid_test_slot.sv
// Bench for mid_test_slot: three slots (nominal, 2-bit error counter,
// single-vector/latency-1) checked every cycle against a run-timeline model.
module tb_mid_test_slot;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Per-slot parameters: 0 = nominal, 1 = ERR_W 2, 2 = NUM_VEC 1 / DUT_LAT 1.
    int pn[3]   = '{16, 16, 1};
    int pl[3]   = '{2, 2, 1};
    int pmax[3] = '{255, 3, 255};

    logic        start[3];
    logic [15:0] fmask[3];
    logic [7:0]  fval[3];

    logic        o_busy[3], o_done[3], o_sv[3], o_cv[3], o_res[3];
    logic [31:0] o_sa[3], o_ca[3], o_err[3], o_fe[3];

    mid_test_slot_if #(.ADDR_W(4), .DATA_W(8), .ERR_W(8)) b0 ();
    mid_test_slot_if #(.ADDR_W(4), .DATA_W(8), .ERR_W(2)) b1 ();
    mid_test_slot_if #(.ADDR_W(4), .DATA_W(8), .ERR_W(8)) b2 ();

    mid_test_slot #(.NUM_VEC(16), .ADDR_W(4), .DATA_W(8), .DUT_LAT(2), .ERR_W(8))
        u0 (.clk_i(clk), .rstn1_i(rstn), .bus(b0));
    mid_test_slot #(.NUM_VEC(16), .ADDR_W(4), .DATA_W(8), .DUT_LAT(2), .ERR_W(2))
        u1 (.clk_i(clk), .rstn1_i(rstn), .bus(b1));
    mid_test_slot #(.NUM_VEC(1), .ADDR_W(4), .DATA_W(8), .DUT_LAT(1), .ERR_W(8))
        u2 (.clk_i(clk), .rstn1_i(rstn), .bus(b2));

    // Emulated DUT: response is addr*3, optionally corrupted by XOR with fval.
    function automatic logic [7:0] dat(input int i, input logic [3:0] a);
        logic [7:0] v;
        v = {4'b0, a} * 8'd3;
        if (fmask[i][a]) v = v ^ fval[i];
        return v;
    endfunction

    logic [7:0] p0a, p0b, p1a, p1b, p2a;
    always @(posedge clk) begin
        p0a <= dat(0, b0.stim_addr);
        p0b <= p0a;
        p1a <= dat(1, b1.stim_addr);
        p1b <= p1a;
        p2a <= dat(2, b2.stim_addr);
    end

    assign b0.start = start[0];
    assign b1.start = start[1];
    assign b2.start = start[2];
    assign b0.dut_data = p0b;
    assign b1.dut_data = p1b;
    assign b2.dut_data = p2a;
    assign b0.exp_data = {4'b0, b0.cmp_addr} * 8'd3;
    assign b1.exp_data = {4'b0, b1.cmp_addr} * 8'd3;
    assign b2.exp_data = {4'b0, b2.cmp_addr} * 8'd3;

    assign o_busy[0] = b0.busy;  assign o_busy[1] = b1.busy;  assign o_busy[2] = b2.busy;
    assign o_done[0] = b0.done;  assign o_done[1] = b1.done;  assign o_done[2] = b2.done;
    assign o_sv[0] = b0.stim_valid; assign o_sv[1] = b1.stim_valid; assign o_sv[2] = b2.stim_valid;
    assign o_cv[0] = b0.cmp_valid;  assign o_cv[1] = b1.cmp_valid;  assign o_cv[2] = b2.cmp_valid;
    assign o_res[0] = b0.result; assign o_res[1] = b1.result; assign o_res[2] = b2.result;
    assign o_sa[0] = 32'(b0.stim_addr); assign o_sa[1] = 32'(b1.stim_addr); assign o_sa[2] = 32'(b2.stim_addr);
    assign o_ca[0] = 32'(b0.cmp_addr);  assign o_ca[1] = 32'(b1.cmp_addr);  assign o_ca[2] = 32'(b2.cmp_addr);
    assign o_err[0] = 32'(b0.err_cnt);  assign o_err[1] = 32'(b1.err_cnt);  assign o_err[2] = 32'(b2.err_cnt);
    assign o_fe[0] = 32'(b0.first_err); assign o_fe[1] = 32'(b1.first_err); assign o_fe[2] = 32'(b2.first_err);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Model: m_c is the cycle number within the current run (0 = idle).
    // Cycle c: stim addr c-1 for c in 1..N, compare addr c-1-L, done at N+L+1.
    int m_c[3]    = '{0, 0, 0};
    int m_err[3]  = '{0, 0, 0};
    int m_ferr[3] = '{0, 0, 0};
    bit m_res[3]  = '{0, 0, 0};

    always @(posedge clk) begin : model
        int c, e, f, a;
        bit r;
        for (int i = 0; i < 3; i++) begin
            c = m_c[i]; e = m_err[i]; f = m_ferr[i]; r = m_res[i];
            if (!rstn) begin
                c = 0; e = 0; f = 0; r = 0;
            end else if (c == 0) begin
                if (start[i]) begin c = 1; e = 0; f = 0; r = 0; end
            end else begin
                a = c - 1 - pl[i];
                if (a >= 0 && a < pn[i] && fmask[i][a]) begin
                    if (e == 0) f = a;
                    if (e < pmax[i]) e = e + 1;
                end
                if (c == pn[i] + pl[i] + 1) begin
                    r = (e == 0);
                    if (start[i]) begin c = 1; e = 0; f = 0; end
                    else c = 0;
                end else begin
                    c = c + 1;
                end
            end
            m_c[i] <= c; m_err[i] <= e; m_ferr[i] <= f; m_res[i] <= r;
        end
    end

    // Per-cycle comparison of every slot against the model.
    always @(negedge clk) begin : compare
        int c;
        bit sv, cv;
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                c  = m_c[i];
                sv = (c >= 1 && c <= pn[i]);
                cv = (c >= pl[i] + 1 && c <= pn[i] + pl[i]);
                chk($sformatf("u%0d.busy", i), 32'(o_busy[i]), 32'(c != 0));
                chk($sformatf("u%0d.done", i), 32'(o_done[i]), 32'(c == pn[i] + pl[i] + 1));
                chk($sformatf("u%0d.stim_valid", i), 32'(o_sv[i]), 32'(sv));
                if (sv) chk($sformatf("u%0d.stim_addr", i), o_sa[i], 32'(c - 1));
                chk($sformatf("u%0d.cmp_valid", i), 32'(o_cv[i]), 32'(cv));
                if (cv) chk($sformatf("u%0d.cmp_addr", i), o_ca[i], 32'(c - 1 - pl[i]));
                chk($sformatf("u%0d.err_cnt", i), o_err[i], 32'(m_err[i]));
                chk($sformatf("u%0d.first_err", i), o_fe[i], 32'(m_ferr[i]));
                chk($sformatf("u%0d.result", i), 32'(o_res[i]), 32'(m_res[i]));
            end
        end
    end

    // One run on slot i; returns the run-relative cycles of done and first stim/cmp valid.
    task automatic run_one(input int i, input logic [15:0] fm, input logic [7:0] fv,
                           input int pulse_at, output int done_at, output int sv_at, output int cv_at);
        fmask[i] = fm; fval[i] = fv; start[i] = 1'b1;
        done_at = 0; sv_at = 0; cv_at = 0;
        @(negedge clk);
        start[i] = 1'b0;
        for (int n = 1; n <= 120; n++) begin
            if (sv_at == 0 && o_sv[i]) sv_at = n;
            if (cv_at == 0 && o_cv[i]) cv_at = n;
            if (o_done[i]) begin done_at = n; break; end
            if (n == pulse_at) start[i] = 1'b1;
            if (n == pulse_at + 1) start[i] = 1'b0;
            @(negedge clk);
        end
        start[i] = 1'b0;
        chk($sformatf("u%0d.done_seen", i), 32'(done_at != 0), 32'd1);
        @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int d, s, cv, k, cnt;
        int dc[3];
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b1; fmask[i] = '0; fval[i] = 8'h01;
        end
        rstn = 1'b0;

        // Reset held two cycles with start high: everything stays zero.
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst.u%0d.busy", i), 32'(o_busy[i]), 32'd0);
            chk($sformatf("rst.u%0d.stim_addr", i), o_sa[i], 32'd0);
            chk($sformatf("rst.u%0d.cmp_addr", i), o_ca[i], 32'd0);
            chk($sformatf("rst.u%0d.err_cnt", i), o_err[i], 32'd0);
            start[i] = 1'b0;
        end
        rstn = 1'b1;
        @(negedge clk);

        // Clean run.
        run_one(0, 16'h0000, 8'h01, 0, d, s, cv);
        chk("pass.done_cycle", 32'(d), 32'd19);
        chk("pass.stim_first", 32'(s), 32'd1);
        chk("pass.cmp_first", 32'(cv), 32'd3);
        chk("pass.result", 32'(o_res[0]), 32'd1);
        chk("pass.err_cnt", o_err[0], 32'd0);

        // Bit0 flipped at addresses 5 and 9, then a clean run restores pass.
        run_one(0, 16'h0220, 8'h01, 0, d, s, cv);
        chk("fail.err_cnt", o_err[0], 32'd2);
        chk("fail.first_err", o_fe[0], 32'd5);
        chk("fail.result", 32'(o_res[0]), 32'd0);
        chk("fail.model_err", 32'(m_err[0]), 32'd2);
        run_one(0, 16'h0000, 8'h01, 0, d, s, cv);
        chk("clean.result", 32'(o_res[0]), 32'd1);
        chk("clean.err_cnt", o_err[0], 32'd0);

        // Saturation on the 2-bit counter.
        run_one(1, 16'hFFFF, 8'h01, 0, d, s, cv);
        chk("sat.err_cnt", o_err[1], 32'd3);
        chk("sat.first_err", o_fe[1], 32'd0);
        chk("sat.result", 32'(o_res[1]), 32'd0);

        // start pulsed during RUN must not produce a second run.
        fmask[0] = '0; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        cnt = 0;
        for (int n = 1; n <= 45; n++) begin
            if (o_done[0]) cnt++;
            start[0] = (n == 5);
            @(negedge clk);
        end
        chk("start_in_run.dones", 32'(cnt), 32'd1);

        // start held high: done every 19 cycles.
        start[0] = 1'b1;
        k = 0;
        @(negedge clk);
        for (int n = 1; n <= 100; n++) begin
            if (o_done[0]) begin
                dc[k] = n; k++;
                if (k == 3) break;
            end
            @(negedge clk);
        end
        start[0] = 1'b0;
        chk("held.dones", 32'(k), 32'd3);
        if (k == 3) begin
            chk("held.first", 32'(dc[0]), 32'd19);
            chk("held.gap1", 32'(dc[1] - dc[0]), 32'd19);
            chk("held.gap2", 32'(dc[2] - dc[1]), 32'd19);
        end
        @(negedge clk);
        @(negedge clk);

        // Reset asserted in cycle 8 aborts the run silently.
        fmask[0] = 16'h0001; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        for (int n = 1; n < 8; n++) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk("abort.busy", 32'(o_busy[0]), 32'd0);
        chk("abort.err_cnt", o_err[0], 32'd0);
        chk("abort.result", 32'(o_res[0]), 32'd0);
        cnt = 0;
        for (int n = 0; n < 30; n++) begin
            if (o_done[0]) cnt++;
            @(negedge clk);
        end
        chk("abort.dones", 32'(cnt), 32'd0);

        // Single vector, latency 1.
        run_one(2, 16'h0000, 8'h01, 0, d, s, cv);
        chk("nv1.stim_cycle", 32'(s), 32'd1);
        chk("nv1.cmp_cycle", 32'(cv), 32'd2);
        chk("nv1.done_cycle", 32'(d), 32'd3);
        chk("nv1.result", 32'(o_res[2]), 32'd1);
        run_one(2, 16'h0001, 8'h80, 0, d, s, cv);
        chk("nv1f.err_cnt", o_err[2], 32'd1);
        chk("nv1f.result", 32'(o_res[2]), 32'd0);

        // Randomized runs across all slots.
        for (int r = 0; r < 24; r++) begin
            int i, pa;
            logic [15:0] fm;
            i  = int'($urandom_range(0, 2));
            fm = 16'($urandom & $urandom);
            pa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, pn[i] + pl[i])) : 0;
            run_one(i, fm, 8'($urandom_range(1, 255)), pa, d, s, cv);
            chk($sformatf("rnd%0d.done_cycle", r), 32'(d), 32'(pn[i] + pl[i] + 1));
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) @(negedge clk);
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
